// File: rtl/add_check_pkg.sv
// Shared definitions for the serial adder result checker.
// Holds the FSM state encoding and the default operand / counter widths.
package add_check_pkg;

  localparam int BITS_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder used as the serial datapath of the checker.
// Ports: a, b, c  - operand bits and carry in
//        s        - sum bit
//        co       - carry out (majority of a, b, c)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/add_result_checker.sv
// Bit-serial checker for the result of an adder under test.
// A transaction {A, B, Cin, Sum, Cout} is captured on a valid/ready handshake,
// the reference sum is recomputed LSB first, one bit per cycle, and a
// one-cycle result pulse reports pass/fail plus the recomputed {Cout,Sum}.
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready  - transaction handshake (ready only when idle)
//        A, B, Cin          - operands and carry-in given to the adder
//        Sum, Cout          - adder outputs being checked
//        res_valid          - one-cycle result strobe
//        res_pass           - 1 when both Sum and Cout matched
//        res_expected       - recomputed {Cout, Sum}
//        pass_cnt, fail_cnt - saturating result counters
//        sticky_err         - set by the first failure, cleared only by reset
module add_result_checker
  import add_check_pkg::*;
#(
  parameter int bits  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [bits-1:0]  A,
  input  logic [bits-1:0]  B,
  input  logic             Cin,
  input  logic [bits-1:0]  Sum,
  input  logic             Cout,
  output logic             res_valid,
  output logic             res_pass,
  output logic [bits:0]    res_expected,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             sticky_err
);

  localparam int IDX_W = $clog2(bits);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [bits-1:0]   a_q;
  logic [bits-1:0]   b_q;
  logic [bits-1:0]   sum_q;
  logic              cout_q;
  logic              carry;
  logic [bits-1:0]   expd;
  logic              mismatch;

  logic              fa_s;
  logic              fa_co;
  logic              mismatch_next;
  logic              last_bit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Operand registers shift right, so bit 0 is always the bit under test.
  full_adder_bit u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign mismatch_next = mismatch | (fa_s != sum_q[0]);
  assign last_bit      = (idx == IDX_W'(bits - 1));
  assign in_ready      = (state == IDLE);
  assign res_valid     = (state == REPORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      carry        <= 1'b0;
      expd         <= '0;
      mismatch     <= 1'b0;
      res_pass     <= 1'b0;
      res_expected <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      sticky_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            sum_q    <= Sum;
            cout_q   <= Cout;
            carry    <= Cin;
            idx      <= '0;
            expd     <= '0;
            mismatch <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          sum_q    <= sum_q >> 1;
          carry    <= fa_co;
          // Sum bits enter at the MSB; after bits shifts bit 0 sits at the LSB.
          expd     <= {fa_s, expd[bits-1:1]};
          mismatch <= mismatch_next;
          idx      <= idx + 1'b1;
          if (last_bit) begin
            // Result is latched here so it is stable throughout REPORT.
            res_pass     <= ~mismatch_next & (fa_co == cout_q);
            res_expected <= {fa_co, fa_s, expd[bits-1:1]};
            state        <= REPORT;
          end
        end
        REPORT: begin
          if (res_pass) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            fail_cnt   <= sat_inc(fail_cnt);
            sticky_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/add_result_checker.md
ADD_RESULT_CHECKER -- requirements
Module: add_result_checker

Interface
REQ-001 Parameter bits, default 8: operand width; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 16: width of the pass/fail counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a transaction is presented on A/B/Cin/Sum/Cout.
REQ-006 in_ready  output  1  checker can accept a transaction.
REQ-007 A, B  input  bits each  adder operands under test.
REQ-008 Cin  input  1  carry-in applied to the adder under test.
REQ-009 Sum  input  bits  sum produced by the adder under test.
REQ-010 Cout  input  1  carry-out produced by the adder under test.
REQ-011 res_valid  output  1  one-cycle pulse; a check result is available.
REQ-012 res_pass  output  1  result of the last check; 1 = Sum and Cout both correct.
REQ-013 res_expected  output  bits+1  recomputed {Cout,Sum} of the last check.
REQ-014 pass_cnt, fail_cnt  output  CNT_W each  saturating check counters.
REQ-015 sticky_err  output  1  set by the first failing check; held until reset.

Function
REQ-016 FSM states: IDLE, RUN, REPORT; in_ready SHALL be 1 only in IDLE.
REQ-017 Handshake: when in_valid=1 and in_ready=1 at an edge, the block SHALL capture A, B, Cin, Sum and Cout, and SHALL enter RUN with bit index 0 and carry=Cin.
REQ-018 In IDLE with in_valid=0, the state SHALL hold; inputs are ignored outside IDLE.
REQ-019 RUN, one bit per cycle, LSB first: s = a^b^c; carry = majority(a,b,c); s SHALL be shifted into the expected register.
REQ-020 A Sum bit mismatch SHALL set an internal mismatch flag, which is cleared on capture.
REQ-021 RUN SHALL last exactly bits cycles; after bit bits-1 the FSM SHALL enter REPORT.
REQ-022 REPORT, one cycle: the final carry SHALL be compared with the captured Cout. res_valid=1, res_pass = no mismatch and Cout equal, res_expected = {carry, expected}. Next state SHALL be IDLE.
REQ-023 Latency: handshake at edge k -> res_valid high from edge k+bits to edge k+bits+1. Maximum throughput SHALL be one check per bits+2 cycles.
REQ-024 Counters and sticky_err SHALL update on the edge leaving REPORT. pass_cnt or fail_cnt increments by 1 and saturates at 2^CNT_W-1 with no wrap.
REQ-025 res_pass and res_expected SHALL hold their values until the next REPORT.
REQ-026 Carry arithmetic SHALL be modulo-free: res_expected = A+B+Cin exactly, in bits+1 bits.

Reset
REQ-027 rst=1 SHALL force IDLE asynchronously. It SHALL clear every output and register to 0: res_valid, res_pass, res_expected, counters, sticky_err and the bit index. in_ready SHALL be 1 after reset.
REQ-028 Reset during RUN or REPORT SHALL abort the check: no res_valid pulse and no counter update.

Structure
REQ-029 Package add_check_pkg SHALL hold the state enum (IDLE/RUN/REPORT) and the default bits and CNT_W constants.
REQ-030 One sub-module, full_adder_bit (a, b, c -> s, co), SHALL be instantiated once for the serial datapath.

Verification
REQ-031 bits=8: Cin=0, A=FF, B=01, Sum=00, Cout=1 -> res_pass=1, res_expected=100, pass_cnt=1.
REQ-032 Back-to-back transactions with in_valid held high:
- 0_AC_47 with Sum=F3, Cout=0 -> pass, expected 0F3.
- 1_BD_38 with Sum=F6, Cout=0 -> pass, expected 0F6.
- 1_EF_27 with Sum=17, Cout=1 -> pass, expected 117.
- in_ready SHALL be low for exactly 9 cycles each, and res_valid SHALL rise at handshake+8.
REQ-033 Fault cases:
- Cin=1, A=EF, B=27, Sum=16, Cout=1 -> res_pass=0, fail_cnt=1, sticky_err=1.
- A following passing check SHALL leave sticky_err=1.
REQ-034 Cout error: A=FF, B=01, Sum=00, Cout=0 -> res_pass=0 and res_expected=100.
REQ-035 Saturation: CNT_W=2 with 5 passing checks -> pass_cnt SHALL stay at 3.
REQ-036 Abort: assert rst 3 cycles after a handshake -> no res_valid pulse, counters 0, in_ready=1; the next transaction SHALL be checked correctly.
